// File: rtl/memaccess.sv
// ============================================================================
// memaccess : memory access stage between execute and writeback.
//             ALU passthrough plus one bus transaction per load or store.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module memaccess #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int REGNO_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_exec_stall,
   input  logic                   i_fetch_stall,
   input  logic [1:0]             i_mem_op,
   input  logic [1:0]             i_mem_size,
   input  logic                   i_mem_sext,
   input  logic [REGNO_WIDTH-1:0] i_dst_gpr,
   input  logic [DATA_WIDTH-1:0]  i_dst_gpr_v,
   input  logic [DATA_WIDTH-1:0]  i_store_data,
   output logic                   o_mem_stall,
   output logic [REGNO_WIDTH-1:0] o_dst_gpr,
   output logic [DATA_WIDTH-1:0]  o_dst_gpr_v,
   output logic                   o_align_err,
   output logic                   o_bus_err,
   output logic [ADDR_WIDTH-1:0]  o_MAddr,
   output logic [2:0]             o_MCmd,
   output logic [DATA_WIDTH-1:0]  o_MData,
   output logic [3:0]             o_MByteEn,
   input  logic                   i_SCmdAccept,
   input  logic [DATA_WIDTH-1:0]  i_SData,
   input  logic [1:0]             i_SResp
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] c_CMD_IDLE  = 3'b000;
   localparam logic [2:0] c_CMD_WRITE = 3'b001;
   localparam logic [2:0] c_CMD_READ  = 3'b010;
   localparam logic [1:0] c_RESP_DVA  = 2'b01;
   localparam logic [1:0] c_RESP_ERR  = 2'b11;

   state_t                 state_q, state_d;
   logic [2:0]             mcmd_q, mcmd_d;
   logic [ADDR_WIDTH-1:0]  maddr_q, maddr_d;
   logic [DATA_WIDTH-1:0]  mdata_q, mdata_d;
   logic [3:0]             mbyteen_q, mbyteen_d;
   logic [REGNO_WIDTH-1:0] dst_gpr_q, dst_gpr_d;
   logic [DATA_WIDTH-1:0]  dst_gpr_v_q, dst_gpr_v_d;
   logic                   align_err_q, align_err_d;
   logic                   bus_err_q, bus_err_d;
   logic [REGNO_WIDTH-1:0] lat_gpr_q, lat_gpr_d;
   logic [1:0]             lat_size_q, lat_size_d;
   logic                   lat_sext_q, lat_sext_d;
   logic [1:0]             lat_lane_q, lat_lane_d;
   logic                   lat_load_q, lat_load_d;

   logic [ADDR_WIDTH-1:0]  w_addr;
   logic                   w_is_load, w_is_store, w_misalign;
   logic [3:0]             w_byteen;
   logic [DATA_WIDTH-1:0]  w_wdata;
   logic [DATA_WIDTH-1:0]  w_shifted, w_load_val;

   assign w_addr     = i_dst_gpr_v[ADDR_WIDTH-1:0];
   assign w_is_load  = (i_mem_op == 2'b01);
   assign w_is_store = (i_mem_op == 2'b10);
   // Reserved size 2'b11 behaves as a word access.
   assign w_misalign = ((i_mem_size == 2'b01) && w_addr[0]) ||
                       (i_mem_size[1] && (w_addr[1:0] != 2'b00));

   always_comb begin
      w_byteen = 4'b1111;
      w_wdata  = i_store_data;
      case (i_mem_size)
         2'b00: begin
            w_byteen = 4'b0001 << w_addr[1:0];
            w_wdata  = {4{i_store_data[7:0]}};
         end
         2'b01: begin
            w_byteen = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata  = {2{i_store_data[15:0]}};
         end
         default: begin
            w_byteen = 4'b1111;
            w_wdata  = i_store_data;
         end
      endcase
   end

   // Half lanes are 0 or 2, so the same byte shift serves both sizes.
   assign w_shifted = i_SData >> {lat_lane_q, 3'b000};

   always_comb begin
      w_load_val = w_shifted;
      case (lat_size_q)
         2'b00:   w_load_val = {{24{lat_sext_q & w_shifted[7]}},  w_shifted[7:0]};
         2'b01:   w_load_val = {{16{lat_sext_q & w_shifted[15]}}, w_shifted[15:0]};
         default: w_load_val = i_SData;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mcmd_d      = mcmd_q;
      maddr_d     = maddr_q;
      mdata_d     = mdata_q;
      mbyteen_d   = mbyteen_q;
      dst_gpr_d   = dst_gpr_q;
      dst_gpr_v_d = dst_gpr_v_q;
      align_err_d = 1'b0;
      bus_err_d   = 1'b0;
      lat_gpr_d   = lat_gpr_q;
      lat_size_d  = lat_size_q;
      lat_sext_d  = lat_sext_q;
      lat_lane_d  = lat_lane_q;
      lat_load_d  = lat_load_q;
      case (state_q)
         IDLE: begin
            if (!(i_exec_stall || i_fetch_stall)) begin
               if (!(w_is_load || w_is_store)) begin
                  dst_gpr_d   = i_dst_gpr;
                  dst_gpr_v_d = i_dst_gpr_v;
               end else if (w_misalign) begin
                  dst_gpr_d   = '0;
                  align_err_d = 1'b1;
               end else begin
                  dst_gpr_d  = '0;
                  lat_gpr_d  = i_dst_gpr;
                  lat_size_d = i_mem_size;
                  lat_sext_d = i_mem_sext;
                  lat_lane_d = w_addr[1:0];
                  lat_load_d = w_is_load;
                  maddr_d    = {w_addr[ADDR_WIDTH-1:2], 2'b00};
                  mdata_d    = w_wdata;
                  mbyteen_d  = w_byteen;
                  mcmd_d     = w_is_load ? c_CMD_READ : c_CMD_WRITE;
                  state_d    = CMD;
               end
            end
         end
         CMD: begin
            if (i_SCmdAccept) begin
               mcmd_d  = c_CMD_IDLE;
               state_d = lat_load_q ? RESP : IDLE;
            end
         end
         RESP: begin
            if (i_SResp == c_RESP_DVA) begin
               dst_gpr_d   = lat_gpr_q;
               dst_gpr_v_d = w_load_val;
               state_d     = IDLE;
            end else if (i_SResp == c_RESP_ERR) begin
               dst_gpr_d = '0;
               bus_err_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mcmd_q      <= c_CMD_IDLE;
         maddr_q     <= '0;
         mdata_q     <= '0;
         mbyteen_q   <= '0;
         dst_gpr_q   <= '0;
         dst_gpr_v_q <= '0;
         align_err_q <= 1'b0;
         bus_err_q   <= 1'b0;
         lat_gpr_q   <= '0;
         lat_size_q  <= '0;
         lat_sext_q  <= 1'b0;
         lat_lane_q  <= '0;
         lat_load_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcmd_q      <= mcmd_d;
         maddr_q     <= maddr_d;
         mdata_q     <= mdata_d;
         mbyteen_q   <= mbyteen_d;
         dst_gpr_q   <= dst_gpr_d;
         dst_gpr_v_q <= dst_gpr_v_d;
         align_err_q <= align_err_d;
         bus_err_q   <= bus_err_d;
         lat_gpr_q   <= lat_gpr_d;
         lat_size_q  <= lat_size_d;
         lat_sext_q  <= lat_sext_d;
         lat_lane_q  <= lat_lane_d;
         lat_load_q  <= lat_load_d;
      end
   end

   assign o_mem_stall = (state_q != IDLE);
   assign o_dst_gpr   = dst_gpr_q;
   assign o_dst_gpr_v = dst_gpr_v_q;
   assign o_align_err = align_err_q;
   assign o_bus_err   = bus_err_q;
   assign o_MAddr     = maddr_q;
   assign o_MCmd      = mcmd_q;
   assign o_MData     = mdata_q;
   assign o_MByteEn   = mbyteen_q;

endmodule

`default_nettype wire

// File: tb/tb_memaccess.sv
// ============================================================================
// tb_memaccess : directed self-checking bench for memaccess.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_memaccess;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_exec_stall, i_fetch_stall;
   logic [1:0]  i_mem_op, i_mem_size;
   logic        i_mem_sext;
   logic [4:0]  i_dst_gpr;
   logic [31:0] i_dst_gpr_v, i_store_data;
   logic        o_mem_stall;
   logic [4:0]  o_dst_gpr;
   logic [31:0] o_dst_gpr_v;
   logic        o_align_err, o_bus_err;
   logic [31:0] o_MAddr;
   logic [2:0]  o_MCmd;
   logic [31:0] o_MData;
   logic [3:0]  o_MByteEn;
   logic        i_SCmdAccept;
   logic [31:0] i_SData;
   logic [1:0]  i_SResp;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   memaccess dut (
      .clk          (clk),
      .rst          (rst),
      .i_exec_stall (i_exec_stall),
      .i_fetch_stall(i_fetch_stall),
      .i_mem_op     (i_mem_op),
      .i_mem_size   (i_mem_size),
      .i_mem_sext   (i_mem_sext),
      .i_dst_gpr    (i_dst_gpr),
      .i_dst_gpr_v  (i_dst_gpr_v),
      .i_store_data (i_store_data),
      .o_mem_stall  (o_mem_stall),
      .o_dst_gpr    (o_dst_gpr),
      .o_dst_gpr_v  (o_dst_gpr_v),
      .o_align_err  (o_align_err),
      .o_bus_err    (o_bus_err),
      .o_MAddr      (o_MAddr),
      .o_MCmd       (o_MCmd),
      .o_MData      (o_MData),
      .o_MByteEn    (o_MByteEn),
      .i_SCmdAccept (i_SCmdAccept),
      .i_SData      (i_SData),
      .i_SResp      (i_SResp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [1:0] op, input logic [1:0] size, input logic sext,
                         input logic [4:0] dst, input logic [31:0] v, input logic [31:0] sd);
      i_mem_op     = op;
      i_mem_size   = size;
      i_mem_sext   = sext;
      i_dst_gpr    = dst;
      i_dst_gpr_v  = v;
      i_store_data = sd;
   endtask

   // Load with immediate accept and DVA on the cycle after accept.
   task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sext, input logic [4:0] dst, input logic [31:0] sdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_v);
      set_op(2'b01, size, sext, dst, addr, 32'h0);
      i_SCmdAccept = 1'b1;
      tick();
      check({tag, ".cmd"},   o_MCmd, 32'd2);
      check({tag, ".addr"},  o_MAddr, addr & 32'hFFFF_FFFC);
      check({tag, ".be"},    o_MByteEn, exp_be);
      check({tag, ".stall"}, o_mem_stall, 1);
      check({tag, ".bubble"}, o_dst_gpr, 0);
      set_op(2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      check({tag, ".cmd_idle"}, o_MCmd, 0);
      i_SCmdAccept = 1'b0;
      i_SResp      = 2'b01;
      i_SData      = sdata;
      tick();
      i_SResp = 2'b00;
      check({tag, ".gpr"},    o_dst_gpr, dst);
      check({tag, ".val"},    o_dst_gpr_v, exp_v);
      check({tag, ".nostall"}, o_mem_stall, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      i_exec_stall = 1'b0;
      i_fetch_stall = 1'b0;
      i_SCmdAccept = 1'b0;
      i_SData = 32'h0;
      i_SResp = 2'b00;
      set_op(2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      check("rst.cmd", o_MCmd, 0);
      check("rst.gpr", o_dst_gpr, 0);
      check("rst.val", o_dst_gpr_v, 0);
      check("rst.stall", o_mem_stall, 0);

      set_op(2'b00, 2'b00, 1'b0, 5'd5, 32'h1234_5678, 32'h0);
      tick();
      check("pass.gpr", o_dst_gpr, 5);
      check("pass.val", o_dst_gpr_v, 32'h1234_5678);
      check("pass.stall", o_mem_stall, 0);
      check("pass.cmd", o_MCmd, 0);

      i_fetch_stall = 1'b1;
      set_op(2'b00, 2'b00, 1'b0, 5'd10, 32'h1, 32'h0);
      tick();
      i_fetch_stall = 1'b0;
      check("hold.gpr", o_dst_gpr, 5);
      check("hold.val", o_dst_gpr_v, 32'h1234_5678);

      run_load("lb_s", 32'h0000_0103, 2'b00, 1'b1, 5'd7, 32'h80AA_BBCC, 4'b1000, 32'hFFFF_FF80);
      run_load("lb_u", 32'h0000_0103, 2'b00, 1'b0, 5'd7, 32'h80AA_BBCC, 4'b1000, 32'h0000_0080);
      run_load("lh_s", 32'h0000_0302, 2'b01, 1'b1, 5'd12, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
      run_load("lbu1", 32'h0000_0301, 2'b00, 1'b0, 5'd13, 32'h8001_F234, 4'b0010, 32'h0000_00F2);

      set_op(2'b10, 2'b01, 1'b0, 5'd9, 32'h0000_0202, 32'h0000_BEEF);
      i_SCmdAccept = 1'b0;
      tick();
      set_op(2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
      check("sh.addr", o_MAddr, 32'h200);
      for (int i = 0; i < 4; i++) begin
         check("sh.cmd", o_MCmd, 1);
         check("sh.be", o_MByteEn, 4'b1100);
         check("sh.data", o_MData, 32'hBEEF_BEEF);
         check("sh.stall", o_mem_stall, 1);
         check("sh.gpr", o_dst_gpr, 0);
         if (i == 3) i_SCmdAccept = 1'b1;
         tick();
      end
      i_SCmdAccept = 1'b0;
      check("sh.done_cmd", o_MCmd, 0);
      check("sh.done_stall", o_mem_stall, 0);

      set_op(2'b01, 2'b10, 1'b0, 5'd3, 32'h0000_0101, 32'h0);
      tick();
      set_op(2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
      check("mis.cmd", o_MCmd, 0);
      check("mis.err", o_align_err, 1);
      check("mis.gpr", o_dst_gpr, 0);
      check("mis.stall", o_mem_stall, 0);
      tick();
      check("mis.pulse", o_align_err, 0);

      set_op(2'b01, 2'b10, 1'b0, 5'd4, 32'h0000_0400, 32'h0);
      i_SCmdAccept = 1'b1;
      tick();
      set_op(2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      i_SCmdAccept = 1'b0;
      i_SResp = 2'b11;
      tick();
      i_SResp = 2'b00;
      check("err.bus", o_bus_err, 1);
      check("err.gpr", o_dst_gpr, 0);
      check("err.stall", o_mem_stall, 0);
      tick();
      check("err.pulse", o_bus_err, 0);

      set_op(2'b01, 2'b10, 1'b0, 5'd6, 32'h0000_0404, 32'h0);
      i_SCmdAccept = 1'b1;
      tick();
      set_op(2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      i_SCmdAccept = 1'b0;
      i_exec_stall = 1'b1;
      i_SResp = 2'b01;
      i_SData = 32'hCAFE_F00D;
      tick();
      i_SResp = 2'b00;
      check("xstall.gpr", o_dst_gpr, 6);
      check("xstall.val", o_dst_gpr_v, 32'hCAFE_F00D);
      check("xstall.stall", o_mem_stall, 0);
      i_exec_stall = 1'b0;

      set_op(2'b01, 2'b10, 1'b0, 5'd11, 32'h0000_0600, 32'h0);
      i_SCmdAccept = 1'b0;
      tick();
      set_op(2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
      i_SCmdAccept = 1'b1;
      i_SResp = 2'b01;
      i_SData = 32'h1111_1111;
      tick();
      i_SCmdAccept = 1'b0;
      i_SResp = 2'b00;
      check("same.stall", o_mem_stall, 1);
      check("same.gpr", o_dst_gpr, 0);
      tick();
      check("same.wait", o_mem_stall, 1);
      i_SResp = 2'b01;
      i_SData = 32'h2222_2222;
      tick();
      i_SResp = 2'b00;
      check("same.gpr2", o_dst_gpr, 11);
      check("same.val", o_dst_gpr_v, 32'h2222_2222);

      set_op(2'b01, 2'b10, 1'b0, 5'd8, 32'h0000_0500, 32'h0);
      i_SCmdAccept = 1'b1;
      tick();
      set_op(2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
      tick();
      i_SCmdAccept = 1'b0;
      check("rstm.inresp", o_mem_stall, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstm.cmd", o_MCmd, 0);
      check("rstm.addr", o_MAddr, 0);
      check("rstm.data", o_MData, 0);
      check("rstm.be", o_MByteEn, 0);
      check("rstm.gpr", o_dst_gpr, 0);
      check("rstm.val", o_dst_gpr_v, 0);
      check("rstm.stall", o_mem_stall, 0);
      i_SResp = 2'b01;
      i_SData = 32'h3333_3333;
      tick();
      i_SResp = 2'b00;
      check("rstm.late_gpr", o_dst_gpr, 0);
      check("rstm.late_val", o_dst_gpr_v, 0);
      check("rstm.late_stall", o_mem_stall, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/memaccess.md
Name: memaccess

Overview:
- Memory access pipeline stage between execute and writeback.
- Passes ALU results through to writeback with one cycle of latency.
- For loads and stores, runs one transaction on the core data bus, which uses an OCP-style command/accept/response handshake.
- Aligns and extends load data, and holds the pipeline with a stall while a transaction is in flight.

Parameters:
- ADDR_WIDTH, 32, data bus byte-address width.
- DATA_WIDTH, 32, register and bus data width; fixed at 32.
- REGNO_WIDTH, 5, GPR index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- i_exec_stall  in  1  execute stage stall.
- i_fetch_stall  in  1  fetch stage stall.
- i_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- i_mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- i_mem_sext  in  1  sign-extend load result.
- i_dst_gpr  in  REGNO_WIDTH  destination GPR; 0 means no write.
- i_dst_gpr_v  in  DATA_WIDTH  ALU result; this is the effective address when i_mem_op is not none.
- i_store_data  in  DATA_WIDTH  store data, right-justified.
- o_mem_stall  out  1  memory stage busy.
- o_dst_gpr  out  REGNO_WIDTH  to writeback.
- o_dst_gpr_v  out  DATA_WIDTH  to writeback.
- o_align_err  out  1  one-cycle pulse: misaligned access.
- o_bus_err  out  1  one-cycle pulse: error response.
- o_MAddr  out  ADDR_WIDTH  word-aligned bus address.
- o_MCmd  out  3  000 idle, 001 write, 010 read.
- o_MData  out  DATA_WIDTH  write data.
- o_MByteEn  out  4  byte enables.
- i_SCmdAccept  in  1  slave accepts command.
- i_SData  in  DATA_WIDTH  read data.
- i_SResp  in  2  00 none, 01 DVA, 11 ERR.

Behaviour:
- Reset: all outputs are registered except o_mem_stall.
  - Synchronous rst=1 forces state IDLE.
  - o_MCmd=0, o_MAddr=0, o_MData=0, o_MByteEn=0.
  - o_dst_gpr=0, o_dst_gpr_v=0, o_align_err=0, o_bus_err=0.
  - Reset mid-transaction abandons it; late i_SResp/i_SCmdAccept is ignored while in IDLE.
- Stall output: o_mem_stall = (state != IDLE), combinational from state.
- FSM states: IDLE, CMD, RESP.
- IDLE, with i_exec_stall or i_fetch_stall high: hold all outputs; o_align_err/o_bus_err are 0.
- IDLE, with neither stall high:
  - Op none: o_dst_gpr/o_dst_gpr_v take the inputs at the next edge.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): no bus command, o_dst_gpr=0, o_align_err=1 for one cycle, stay IDLE.
  - Aligned load/store: o_dst_gpr<=0 (bubble to writeback); latch i_dst_gpr, size and sext internally; drive o_MAddr={addr[31:2],2'b00}; go CMD.
    - Load: o_MCmd=010.
    - Store: o_MCmd=001.
- Byte lanes (little-endian; lane k = bits 8k+7:8k):
  - Byte: o_MByteEn=1<<addr[1:0].
  - Half: o_MByteEn=0011 if addr[1]=0, 1100 if addr[1]=1.
  - Word: o_MByteEn=1111.
  - o_MData replicates the store data: byte x4, half x2, word as-is.
- CMD: o_MCmd/o_MAddr/o_MData/o_MByteEn are held stable until i_SCmdAccept=1. At the accepting edge, o_MCmd<=000, then:
  - Store: go IDLE (stores have no response phase).
  - Load: go RESP.
- RESP: wait for i_SResp != 00.
  - DVA: extract the addressed lane(s) of i_SData, then sign- or zero-extend per the latched sext. o_dst_gpr<=latched GPR, o_dst_gpr_v<=result, go IDLE.
  - ERR: o_dst_gpr<=0, o_bus_err=1 for one cycle, go IDLE.
  - A response is sampled only in RESP.
- Hazard rules:
  - i_SCmdAccept and i_SResp in the same cycle while in CMD: the response is ignored (a same-cycle response is illegal on this bus).
  - Execute/fetch stalls are ignored while state != IDLE; a transaction always completes.
  - Execute holds its outputs while o_mem_stall=1.
- Writeback handoff:
  - Writeback freezes while o_mem_stall=1.
  - The load result is presented at the edge that returns to IDLE and is captured by writeback one cycle later.
  - That cycle, IDLE may accept the next instruction.
- Latency:
  - ALU op: 1 cycle.
  - Load: 1 + accept wait + 1 + response wait cycles.
  - Store: 1 + accept wait.

Test Plan:
- Passthrough: op none, dst=5, v=0x12345678, no stalls -> next cycle o_dst_gpr=5, o_dst_gpr_v=0x12345678, o_mem_stall=0, o_MCmd=0.
- LB sign-extend: addr 0x00000103, sext=1, accept immediate, DVA next cycle with i_SData=0x80AABBCC -> o_MAddr=0x100, o_MByteEn=1000, o_dst_gpr_v=0xFFFFFF80; with sext=0 -> 0x00000080.
- SH with slow accept: addr 0x202, data 0x0000BEEF, i_SCmdAccept delayed 3 cycles -> o_MCmd=001, o_MByteEn=1100, o_MData=0xBEEFBEEF held 4 cycles, o_mem_stall=1 throughout, o_dst_gpr=0, IDLE after accept.
- Misaligned LW at 0x101 -> o_MCmd stays 0, o_align_err pulses 1 cycle, o_dst_gpr=0, no stall.
- Error response: LW 0x400, i_SResp=ERR -> o_bus_err pulses once, o_dst_gpr=0, returns IDLE; with i_exec_stall held high during RESP, DVA completes normally.
- Reset mid-load in RESP -> next cycle all outputs 0, o_mem_stall=0; a DVA arriving afterwards produces no write.
